seq_alu: RTL and testbench

- Parametrised, clocked successor to the 32-bit combinational ALU, with the same opcode map.
- Single-cycle logic and arithmetic ops are registered.
- Adds an iterative signed multiply that returns the full 2*WIDTH product, plus a new iterative unsigned divide.
- Uses a START/BUSY/DONE handshake so the controller in the datapath can stall on multi-cycle ops.

---
 rtl/seq_alu.sv | 177 +++++++++++++++++
 tb/tb_seq_alu.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - clocked ALU with registered single-cycle ops and iterative signed MUL / unsigned DIVU
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [5:0]       OPRN,
  input  logic [WIDTH-1:0] OP1,
  input  logic [WIDTH-1:0] OP2,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] OUT,
  output logic [WIDTH-1:0] HI,
  output logic             ZERO
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_MUL  = 4'h3;
  localparam logic [3:0] OP_SRL  = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_NOR  = 4'h8;
  localparam logic [3:0] OP_SLT  = 4'h9;
  localparam logic [3:0] OP_DIVU = 4'hA;

  // Final iteration index: the WIDTH-th step runs while cnt holds this value.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         op;
  logic               unused_oprn;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   abs1;
  logic [WIDTH-1:0]   abs2;

  // Multiplier: magnitude multiplicand plus a combined {partial, multiplier} shift register.
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic               neg;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] mul_final;

  // Divider: remainder, dividend shifting out / quotient shifting in, latched divisor.
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic               div_ok;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;

  assign op          = OPRN[3:0];
  assign unused_oprn = ^OPRN[5:4];
  assign BUSY        = (state != S_IDLE);
  assign abs1        = OP1[WIDTH-1] ? -OP1 : OP1;
  assign abs2        = OP2[WIDTH-1] ? -OP2 : OP2;

  // Single-cycle result; shifts by WIDTH or more fall out to zero naturally.
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD: alu_res = OP1 + OP2;
      OP_SUB: alu_res = OP1 - OP2;
      OP_SRL: alu_res = OP1 >> OP2;
      OP_SLL: alu_res = OP1 << OP2;
      OP_AND: alu_res = OP1 & OP2;
      OP_OR:  alu_res = OP1 | OP2;
      OP_NOR: alu_res = ~(OP1 | OP2);
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(OP1) < $signed(OP2))};
      default: alu_res = '0;
    endcase
  end

  // One shift-add step on the magnitudes, plus sign fix-up for the final load.
  always_comb begin
    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    mul_next  = {mul_sum, prod[WIDTH-1:1]};
    mul_final = neg ? -mul_next : mul_next;
  end

  // One restoring-division step; a zero divisor never borrows, giving all-ones quotient.
  always_comb begin
    div_shift = {rem, quo[WIDTH-1]};
    div_trial = div_shift - {1'b0, divisor};
    div_ok    = ~div_trial[WIDTH];
    rem_next  = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    quo_next  = {quo[WIDTH-2:0], div_ok};
  end

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= S_IDLE;
      cnt     <= '0;
      OUT     <= '0;
      HI      <= '0;
      ZERO    <= 1'b1;
      DONE    <= 1'b0;
      mcand   <= '0;
      prod    <= '0;
      neg     <= 1'b0;
      divisor <= '0;
      rem     <= '0;
      quo     <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            case (op)
              OP_MUL: begin
                mcand <= abs1;
                prod  <= {{WIDTH{1'b0}}, abs2};
                neg   <= OP1[WIDTH-1] ^ OP2[WIDTH-1];
                cnt   <= '0;
                state <= S_MUL;
              end
              OP_DIVU: begin
                divisor <= OP2;
                quo     <= OP1;
                rem     <= '0;
                cnt     <= '0;
                state   <= S_DIV;
              end
              default: begin
                OUT  <= alu_res;
                HI   <= '0;
                ZERO <= (alu_res == '0);
                DONE <= 1'b1;
              end
            endcase
          end
        end
        S_MUL: begin
          if (cnt == LAST) begin
            OUT   <= mul_final[WIDTH-1:0];
            HI    <= mul_final[2*WIDTH-1:WIDTH];
            ZERO  <= (mul_final[WIDTH-1:0] == '0);
            DONE  <= 1'b1;
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            prod <= mul_next;
            cnt  <= cnt + 1'b1;
          end
        end
        S_DIV: begin
          if (cnt == LAST) begin
            OUT   <= quo_next;
            HI    <= rem_next;
            ZERO  <= (quo_next == '0);
            DONE  <= 1'b1;
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            rem <= rem_next;
            quo <= quo_next;
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - scoreboard bench for seq_alu at WIDTH=32 and WIDTH=8
module tb_seq_alu;

  typedef struct {
    int          id;
    logic [31:0] out;
    logic [31:0] hi;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [5:0]  oprn;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] out;
    logic [31:0] hi;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        start32, start8;
  logic [5:0]  oprn32, oprn8;
  logic [31:0] op1_32, op2_32, out32, hi32;
  logic [7:0]  op1_8, op2_8, out8, hi8;
  logic        busy32, done32, zero32;
  logic        busy8, done8, zero8;

  int   cyc;
  int   n_cmp;
  int   n_bad;
  int   ids;
  exp_t q32[$];
  exp_t q8[$];
  exp_t m32, m8;
  vec_t tbl[15];

  seq_alu #(.WIDTH(32), .CNT_W(6)) dut32 (
    .CLK(clk), .RST(rst), .START(start32), .OPRN(oprn32), .OP1(op1_32), .OP2(op2_32),
    .BUSY(busy32), .DONE(done32), .OUT(out32), .HI(hi32), .ZERO(zero32)
  );

  seq_alu #(.WIDTH(8), .CNT_W(4)) dut8 (
    .CLK(clk), .RST(rst), .START(start8), .OPRN(oprn8), .OP1(op1_8), .OP2(op2_8),
    .BUSY(busy8), .DONE(done8), .OUT(out8), .HI(hi8), .ZERO(zero8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard for the 32-bit instance: every DONE must match the oldest pending op.
  always @(negedge clk) begin
    if (!rst && done32) begin
      if (q32.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done32_unexpected: got DONE at cycle %0d, expected no DONE", cyc);
      end else begin
        m32 = q32.pop_front();
        chk($sformatf("op%0d_out", m32.id), out32, m32.out);
        chk($sformatf("op%0d_hi", m32.id), hi32, m32.hi);
        chk($sformatf("op%0d_zero", m32.id), {31'b0, zero32}, {31'b0, (m32.out == 32'b0)});
        chk($sformatf("op%0d_latency", m32.id), cyc, m32.cyc);
      end
    end
  end

  // Scoreboard for the 8-bit instance.
  always @(negedge clk) begin
    if (!rst && done8) begin
      if (q8.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done8_unexpected: got DONE at cycle %0d, expected no DONE", cyc);
      end else begin
        m8 = q8.pop_front();
        chk($sformatf("op%0d_out", m8.id), {24'b0, out8}, m8.out);
        chk($sformatf("op%0d_hi", m8.id), {24'b0, hi8}, m8.hi);
        chk($sformatf("op%0d_zero", m8.id), {31'b0, zero8}, {31'b0, (m8.out == 32'b0)});
        chk($sformatf("op%0d_latency", m8.id), cyc, m8.cyc);
      end
    end
  end

  // Called at posedge+1; START is sampled at the next edge (E0).
  task automatic issue32(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eo, input logic [31:0] eh, input int lat);
    exp_t e;
    oprn32  = o;
    op1_32  = a;
    op2_32  = b;
    start32 = 1'b1;
    e.id  = ids;
    ids++;
    e.out = eo;
    e.hi  = eh;
    e.cyc = cyc + 1 + lat;
    q32.push_back(e);
    @(posedge clk);
    #1;
    start32 = 1'b0;
  endtask

  task automatic issue8(input logic [5:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eo, input logic [7:0] eh, input int lat);
    exp_t e;
    oprn8  = o;
    op1_8  = a;
    op2_8  = b;
    start8 = 1'b1;
    e.id  = ids;
    ids++;
    e.out = {24'b0, eo};
    e.hi  = {24'b0, eh};
    e.cyc = cyc + 1 + lat;
    q8.push_back(e);
    @(posedge clk);
    #1;
    start8 = 1'b0;
  endtask

  task automatic drain32(input int budget);
    int n = 0;
    while (q32.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain32_timeout", q32.size(), 0);
  endtask

  task automatic drain8(input int budget);
    int n = 0;
    while (q8.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain8_timeout", q8.size(), 0);
  endtask

  initial begin
    int nd;
    cyc = 0; n_cmp = 0; n_bad = 0; ids = 0;
    rst = 1'b1;
    start32 = 1'b0; oprn32 = '0; op1_32 = '0; op2_32 = '0;
    start8  = 1'b0; oprn8  = '0; op1_8  = '0; op2_8  = '0;

    tbl[0]  = '{6'h01, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h0};
    tbl[1]  = '{6'h02, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 32'h0};
    tbl[2]  = '{6'h05, 32'h0000_0001, 32'd31,        32'h8000_0000, 32'h0};
    tbl[3]  = '{6'h04, 32'hDEAD_BEEF, 32'd32,        32'h0000_0000, 32'h0};
    tbl[4]  = '{6'h04, 32'h8000_0000, 32'd4,         32'h0800_0000, 32'h0};
    tbl[5]  = '{6'h08, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0};
    tbl[6]  = '{6'h06, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 32'h0};
    tbl[7]  = '{6'h07, 32'h0F00_0000, 32'h0000_00F0, 32'h0F00_00F0, 32'h0};
    tbl[8]  = '{6'h09, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0};
    tbl[9]  = '{6'h09, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'h0};
    tbl[10] = '{6'h09, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 32'h0};
    tbl[11] = '{6'h31, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 32'h0};
    tbl[12] = '{6'h0B, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 32'h0};
    tbl[13] = '{6'h00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0};
    tbl[14] = '{6'h01, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0};

    #7;
    chk("rst_out32", out32, 32'h0);
    chk("rst_hi32", hi32, 32'h0);
    chk("rst_zero32", {31'b0, zero32}, 32'h1);
    chk("rst_busy32", {31'b0, busy32}, 32'h0);
    chk("rst_done32", {31'b0, done32}, 32'h0);
    chk("rst_out8", {24'b0, out8}, 32'h0);
    chk("rst_zero8", {31'b0, zero8}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single-cycle ops issued back-to-back, one per cycle.
    for (int i = 0; i < 15; i++)
      issue32(tbl[i].oprn, tbl[i].op1, tbl[i].op2, tbl[i].out, tbl[i].hi, 0);
    drain32(10);

    // MUL with START pulsed and operands disturbed while busy.
    issue32(6'h03, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 32);
    chk("mul_busy", {31'b0, busy32}, 32'h1);
    repeat (3) begin
      @(posedge clk);
      #1;
      start32 = 1'b1;
      oprn32  = 6'h01;
      op1_32  = 32'h5;
      op2_32  = 32'h6;
    end
    @(posedge clk);
    #1;
    start32 = 1'b0;
    drain32(40);
    repeat (4) @(posedge clk);
    #1;

    issue32(6'h03, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32);
    drain32(40);
    issue32(6'h03, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 32);
    drain32(40);
    issue32(6'h03, 32'h0001_2345, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32);
    drain32(40);

    // DIVU, including divide-by-zero and a zero quotient.
    issue32(6'h0A, 32'd100,       32'd7, 32'd14,        32'd2, 32);
    drain32(40);
    issue32(6'h0A, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 32);
    drain32(40);
    issue32(6'h0A, 32'd3,         32'd5, 32'd0,         32'd3, 32);
    drain32(40);
    issue32(6'h0A, 32'd9,         32'd0, 32'hFFFF_FFFF, 32'd9, 32);
    drain32(40);

    // Asynchronous reset mid-cycle clears the held 9/0 result at once.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out32", out32, 32'h0);
    chk("arst_hi32", hi32, 32'h0);
    chk("arst_zero32", {31'b0, zero32}, 32'h1);
    chk("arst_busy32", {31'b0, busy32}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset around step 10 of a MUL abandons it with no DONE.
    issue32(6'h03, 32'h0000_0011, 32'h0000_0013, 32'h0, 32'h0, 32);
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b1;
    q32.delete();
    #1;
    chk("mulrst_busy32", {31'b0, busy32}, 32'h0);
    chk("mulrst_done32", {31'b0, done32}, 32'h0);
    #2;
    rst = 1'b0;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done32) nd++;
    end
    chk("mulrst_no_done", nd, 0);
    @(posedge clk);
    #1;
    issue32(6'h03, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 32);
    drain32(40);

    // WIDTH=8 instance.
    issue8(6'h03, 8'h80, 8'h80, 8'h00, 8'h40, 8);
    drain8(20);
    issue8(6'h03, 8'h7F, 8'h80, 8'h80, 8'hC0, 8);
    drain8(20);
    issue8(6'h0A, 8'd200, 8'd3, 8'd66, 8'd2, 8);
    drain8(20);
    issue8(6'h0C, 8'h12, 8'h34, 8'h00, 8'h00, 0);
    drain8(20);

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
